fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Bundles the fetch controller's hazard inputs, PC/pipeline-register
// control outputs and its observable state/counters into one port.
interface fetch_ctrl_if;
  logic        imem_ready;
  logic        load_use;
  logic        jmp;
  logic        br_taken;
  logic        holdPC;
  logic        PCsrc;
  logic        isBranch;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        flush_idex;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // The pipeline side supplies hazard inputs and observes the controls
  modport master (
    output imem_ready, load_use, jmp, br_taken,
    input  holdPC, PCsrc, isBranch, stall_ifid, flush_ifid, flush_idex,
    input  state, stall_cnt, flush_cnt
  );

  // The controller consumes hazard inputs and drives the controls
  modport slave (
    input  imem_ready, load_use, jmp, br_taken,
    output holdPC, PCsrc, isBranch, stall_ifid, flush_ifid, flush_idex,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage hazard controller: decides per cycle whether the PC advances,
// holds, or is redirected by a branch/jump, and which pipeline registers
// are stalled or flushed. Also counts stall and redirect cycles.
module fetch_ctrl #(
  parameter int LU_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEMWAIT  = 2'd1,
    LU_STALL = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [2:0] LU_LOAD = 3'(LU_CYCLES - 1);

  state_t      state_q, next_state;
  logic [2:0]  lu_cnt_q, lu_next;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        hold, pcsrc, isbr, stall_ifid, flush_ifid, flush_idex;

  // Register the FSM state and the load-use bubble countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= next_state;
      lu_cnt_q <= lu_next;
    end
  end

  // Next state and control outputs; reset forces every control low, and
  // a taken branch always wins because it resolves the oldest instruction
  always_comb begin
    next_state = state_q;
    lu_next    = lu_cnt_q;
    hold       = 1'b0;
    pcsrc      = 1'b0;
    isbr       = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst) begin
      if (bus.br_taken) begin
        isbr       = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        next_state = FLUSH;
      end else begin
        unique case (state_q)
          RUN: begin
            if (bus.jmp) begin
              pcsrc      = 1'b1;
              flush_ifid = 1'b1;
              next_state = FLUSH;
            end else if (bus.load_use) begin
              hold       = 1'b1;
              stall_ifid = 1'b1;
              flush_idex = 1'b1;
              lu_next    = LU_LOAD;
              next_state = (LU_CYCLES > 1) ? LU_STALL : RUN;
            end else if (!bus.imem_ready) begin
              hold       = 1'b1;
              stall_ifid = 1'b1;
              next_state = MEMWAIT;
            end
          end
          LU_STALL: begin
            hold       = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            lu_next    = lu_cnt_q - 3'd1;
            if (lu_cnt_q <= 3'd1) next_state = RUN;
          end
          MEMWAIT: begin
            if (!bus.imem_ready) begin
              hold       = 1'b1;
              stall_ifid = 1'b1;
            end else begin
              next_state = RUN;
            end
          end
          FLUSH: begin
            flush_ifid = 1'b1;
            if (bus.imem_ready) begin
              next_state = RUN;
            end else begin
              hold       = 1'b1;
              next_state = MEMWAIT;
            end
          end
          default: next_state = RUN;
        endcase
      end
    end
  end

  // Saturating counters of held-PC cycles and redirect cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (hold && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((isbr || pcsrc) && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.holdPC     = hold;
  assign bus.PCsrc      = pcsrc;
  assign bus.isBranch   = isbr;
  assign bus.stall_ifid = stall_ifid;
  assign bus.flush_ifid = flush_ifid;
  assign bus.flush_idex = flush_idex;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with LU_CYCLES=3. Inputs change right
// after the falling edge and outputs are sampled before the next rising edge.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  fetch_ctrl_if ifc();

  fetch_ctrl #(.LU_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Control vector order: {holdPC, PCsrc, isBranch, stall_ifid, flush_ifid, flush_idex}
  function automatic logic [15:0] ctrl();
    return {10'd0, ifc.holdPC, ifc.PCsrc, ifc.isBranch,
            ifc.stall_ifid, ifc.flush_ifid, ifc.flush_idex};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic j,
                               input logic lu, input logic rdy);
    ifc.br_taken   = br;
    ifc.jmp        = j;
    ifc.load_use   = lu;
    ifc.imem_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with every hazard input asserted: controls must stay low
    rst = 1'b1;
    applyStimulus(1, 1, 1, 0);
    checkOutput("reset_ctrl", ctrl(), 16'h0000);
    step();
    step();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset_state", 16'(ifc.state), 16'd0);
    checkOutput("reset_stall_cnt", ifc.stall_cnt, 16'd0);
    checkOutput("reset_flush_cnt", ifc.flush_cnt, 16'd0);
    checkOutput("run_idle_ctrl", ctrl(), 16'h0000);

    // Load-use pulse: three bubble cycles, jmp ignored while stalled
    applyStimulus(0, 0, 1, 1);
    checkOutput("lu_run_ctrl", ctrl(), 16'h0025);
    step();
    applyStimulus(0, 1, 1, 1);
    checkOutput("lu_stall1_state", 16'(ifc.state), 16'd2);
    checkOutput("lu_stall1_ctrl", ctrl(), 16'h0025);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("lu_stall2_state", 16'(ifc.state), 16'd2);
    checkOutput("lu_stall2_ctrl", ctrl(), 16'h0025);
    step();
    checkOutput("lu_done_state", 16'(ifc.state), 16'd0);
    checkOutput("lu_done_ctrl", ctrl(), 16'h0000);
    checkOutput("lu_stall_cnt", ifc.stall_cnt, 16'd3);

    // Memory not ready for four cycles, jmp/load_use ignored in MEMWAIT
    applyStimulus(0, 0, 0, 0);
    checkOutput("mem_run_ctrl", ctrl(), 16'h0024);
    for (int i = 0; i < 3; i++) begin
      step();
      applyStimulus(0, 1, 1, 0);
      checkOutput("mem_wait_state", 16'(ifc.state), 16'd1);
      checkOutput("mem_wait_ctrl", ctrl(), 16'h0024);
    end
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("mem_ready_state", 16'(ifc.state), 16'd1);
    checkOutput("mem_ready_ctrl", ctrl(), 16'h0000);
    step();
    checkOutput("mem_done_state", 16'(ifc.state), 16'd0);
    checkOutput("mem_stall_cnt", ifc.stall_cnt, 16'd7);

    // Branch and jump together: branch wins
    applyStimulus(1, 1, 0, 1);
    checkOutput("brjmp_ctrl", ctrl(), 16'h000B);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("brjmp_flush_state", 16'(ifc.state), 16'd3);
    checkOutput("brjmp_flush_ctrl", ctrl(), 16'h0002);
    checkOutput("brjmp_flush_cnt", ifc.flush_cnt, 16'd1);
    step();
    checkOutput("brjmp_done_state", 16'(ifc.state), 16'd0);
    checkOutput("brjmp_done_cnt", ifc.flush_cnt, 16'd1);

    // Jump alone, then FLUSH with memory not ready goes to MEMWAIT
    applyStimulus(0, 1, 0, 1);
    checkOutput("jmp_ctrl", ctrl(), 16'h0012);
    step();
    applyStimulus(0, 1, 1, 0);
    checkOutput("jmp_flush_state", 16'(ifc.state), 16'd3);
    checkOutput("jmp_flush_ctrl", ctrl(), 16'h0022);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("jmp_memwait_state", 16'(ifc.state), 16'd1);
    checkOutput("jmp_flush_cnt", ifc.flush_cnt, 16'd2);
    checkOutput("jmp_stall_cnt", ifc.stall_cnt, 16'd8);
    checkOutput("jmp_memwait_ctrl", ctrl(), 16'h0000);
    step();
    checkOutput("jmp_done_state", 16'(ifc.state), 16'd0);

    // Branch taken inside FLUSH re-redirects and stays in FLUSH
    applyStimulus(1, 0, 0, 1);
    step();
    applyStimulus(1, 0, 0, 1);
    checkOutput("rebr_ctrl", ctrl(), 16'h000B);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("rebr_state", 16'(ifc.state), 16'd3);
    step();
    checkOutput("rebr_done_state", 16'(ifc.state), 16'd0);
    checkOutput("rebr_flush_cnt", ifc.flush_cnt, 16'd4);

    // Branch aborts a load-use stall
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(0, 0, 1, 1);
    checkOutput("abort_cnt_clear", ifc.stall_cnt, 16'd0);
    step();
    applyStimulus(1, 0, 0, 1);
    checkOutput("abort_stall_state", 16'(ifc.state), 16'd2);
    checkOutput("abort_ctrl", ctrl(), 16'h000B);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort_flush_state", 16'(ifc.state), 16'd3);
    step();
    checkOutput("abort_done_state", 16'(ifc.state), 16'd0);
    checkOutput("abort_stall_cnt", ifc.stall_cnt, 16'd1);
    checkOutput("abort_flush_cnt", ifc.flush_cnt, 16'd1);

    // Stall counter saturation from a preloaded value
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    checkOutput("sat_preload", ifc.stall_cnt, 16'hFFFE);
    applyStimulus(0, 0, 1, 1);
    step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("sat_first", ifc.stall_cnt, 16'hFFFF);
    step();
    checkOutput("sat_second", ifc.stall_cnt, 16'hFFFF);
    step();
    checkOutput("sat_third", ifc.stall_cnt, 16'hFFFF);
    checkOutput("sat_state", 16'(ifc.state), 16'd0);

    // Reset during MEMWAIT abandons the wait cleanly
    applyStimulus(0, 0, 0, 0);
    step();
    checkOutput("rstmw_state_before", 16'(ifc.state), 16'd1);
    rst = 1'b1;
    applyStimulus(1, 1, 1, 0);
    checkOutput("rstmw_ctrl", ctrl(), 16'h0000);
    step();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("rstmw_state", 16'(ifc.state), 16'd0);
    checkOutput("rstmw_stall_cnt", ifc.stall_cnt, 16'd0);
    checkOutput("rstmw_flush_cnt", ifc.flush_cnt, 16'd0);
    checkOutput("rstmw_after_ctrl", ctrl(), 16'h0000);
    step();
    checkOutput("rstmw_idle_state", 16'(ifc.state), 16'd0);
    checkOutput("rstmw_idle_ctrl", ctrl(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
